nibble_scatter_bank: RTL and testbench

- Write-side counterpart of the multiplier's 32-to-1 4-bit nibble select.
- Scatters a stream of 4-bit nibbles into a 32-entry x 4-bit register bank, using a 5-bit auto-incrementing slot pointer that wraps.
- Exposes the whole bank flattened as 128 bits. Also supports a one-cycle addressed single-slot write and a combinational addressed nibble readback.
- Sits in the Multiplier datapath. It assembles partial-product nibbles for later selection.

---
 rtl/nibble_scatter_bank.sv | 134 +++++++++++++
 tb/tb_nibble_scatter_bank.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_scatter_bank.sv
// 32-slot x 4-bit register bank filled by an auto-incrementing nibble stream,
// with an addressed single-slot write and a combinational readback.
module nibble_scatter_bank #(
    parameter int NSLOT = 32,
    parameter int W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Start,
    input  logic [4:0]           Start_sel,
    input  logic [5:0]           Len,
    input  logic [W-1:0]         In,
    input  logic                 In_valid,
    output logic                 In_ready,
    input  logic                 Wr_en,
    input  logic [4:0]           Wr_sel,
    input  logic [W-1:0]         Wr_data,
    input  logic                 Clear,
    input  logic [4:0]           Rd_sel,
    output logic [W-1:0]         Rd_out,
    output logic [NSLOT*W-1:0]   Bank_flat,
    output logic                 Busy,
    output logic                 Done,
    output logic [4:0]           Ptr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [4:0]   r_ptr;
    logic [4:0]   w_ptr_nxt;
    logic [5:0]   r_rem;
    logic [5:0]   w_rem_nxt;
    logic         w_we;
    logic [4:0]   w_wsel;
    logic [W-1:0] w_wdata;
    logic         w_clr;
    logic [W-1:0] r_bank [NSLOT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Clear outranks everything; a single write port serves both the
    // addressed write (IDLE) and the stream write (FILL).
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_rem;
        w_we        = 1'b0;
        w_wsel      = r_ptr;
        w_wdata     = In;
        w_clr       = 1'b0;
        if (Clear) begin
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = '0;
            w_rem_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        w_ptr_nxt   = Start_sel;
                        w_rem_nxt   = (Len > 6'd32) ? 6'd32 : Len;
                        w_state_nxt = (Len == 6'd0) ? ST_DONE : ST_FILL;
                    end else if (Wr_en) begin
                        w_we    = 1'b1;
                        w_wsel  = Wr_sel;
                        w_wdata = Wr_data;
                    end
                end
                ST_FILL: begin
                    if (In_valid) begin
                        w_we      = 1'b1;
                        w_wsel    = r_ptr;
                        w_wdata   = In;
                        w_ptr_nxt = r_ptr + 5'd1;
                        w_rem_nxt = r_rem - 6'd1;
                        if (r_rem == 6'd1) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                r_bank[k] <= '0;
            end
        end else if (w_clr) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                r_bank[k] <= '0;
            end
        end else if (w_we) begin
            r_bank[w_wsel] <= w_wdata;
        end
    end

    always_comb begin
        Bank_flat = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            Bank_flat[k*W +: W] = r_bank[k];
        end
    end

    assign Rd_out   = r_bank[Rd_sel];
    assign Busy     = (r_state == ST_FILL);
    assign In_ready = (r_state == ST_FILL);
    assign Done     = (r_state == ST_DONE);
    assign Ptr      = r_ptr;

endmodule

// File: tb/tb_nibble_scatter_bank.sv
// Scoreboarded bench for nibble_scatter_bank: directed bursts plus random
// traffic checked against an array-based reference model.
module tb_nibble_scatter_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [4:0]   Start_sel;
    logic [5:0]   Len;
    logic [3:0]   In;
    logic         In_valid;
    logic         In_ready;
    logic         Wr_en;
    logic [4:0]   Wr_sel;
    logic [3:0]   Wr_data;
    logic         Clear;
    logic [4:0]   Rd_sel;
    logic [3:0]   Rd_out;
    logic [127:0] Bank_flat;
    logic         Busy;
    logic         Done;
    logic [4:0]   Ptr;

    always #5 clk = ~clk;

    nibble_scatter_bank #(.NSLOT(32), .W(4)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Start_sel(Start_sel),
        .Len(Len), .In(In), .In_valid(In_valid), .In_ready(In_ready),
        .Wr_en(Wr_en), .Wr_sel(Wr_sel), .Wr_data(Wr_data), .Clear(Clear),
        .Rd_sel(Rd_sel), .Rd_out(Rd_out), .Bank_flat(Bank_flat),
        .Busy(Busy), .Done(Done), .Ptr(Ptr)
    );

    typedef struct {
        logic [127:0] bank;
        logic [4:0]   ptr;
        logic         busy;
        logic         rdy;
        logic         done;
        logic [3:0]   rd;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: plain array of slots, a pointer, a count of nibbles
    // still owed, and two flags for "a burst is open" / "completion cycle".
    logic [3:0] m_bank [32];
    logic [4:0] m_ptr;
    int         m_left;
    bit         m_fill;
    bit         m_done;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] m_flat();
        logic [127:0] v;
        for (int k = 0; k < 32; k++) v[k*4 +: 4] = m_bank[k];
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 32; k++) m_bank[k] = 4'h0;
        m_ptr  = 5'd0;
        m_left = 0;
        m_fill = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic void model_step();
        if (reset || Clear) begin
            model_clear();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_fill) begin
            if (In_valid) begin
                m_bank[m_ptr] = In;
                m_ptr  = m_ptr + 5'd1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_fill = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (Start) begin
            m_ptr  = Start_sel;
            m_left = (int'(Len) > 32) ? 32 : int'(Len);
            if (m_left == 0) m_done = 1'b1;
            else             m_fill = 1'b1;
        end else if (Wr_en) begin
            m_bank[Wr_sel] = Wr_data;
        end
    endfunction

    // One clock: model consumes the inputs seen at the edge, the expected
    // post-edge view is queued, and new inputs may be driven after negedge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_step();
        e.bank = m_flat();
        e.ptr  = m_ptr;
        e.busy = m_fill;
        e.rdy  = m_fill;
        e.done = m_done;
        e.rd   = m_bank[Rd_sel];
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("bank_flat", Bank_flat, e.bank);
                chk("ptr",       {123'd0, Ptr},      {123'd0, e.ptr});
                chk("busy",      {127'd0, Busy},     {127'd0, e.busy});
                chk("in_ready",  {127'd0, In_ready}, {127'd0, e.rdy});
                chk("done",      {127'd0, Done},     {127'd0, e.done});
                chk("rd_out",    {124'd0, Rd_out},   {124'd0, e.rd});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic quiet();
        Start = 0; Start_sel = 0; Len = 0; In = 0; In_valid = 0;
        Wr_en = 0; Wr_sel = 0; Wr_data = 0; Clear = 0;
    endtask

    initial begin
        logic [127:0] expv;
        logic [3:0]   vals [4];
        int           acc;
        int           budget;

        model_clear();
        quiet();
        Rd_sel = 0;
        reset  = 1;
        cycle(); cycle();
        reset = 0;
        cycle();
        chk("reset_bank", Bank_flat, 128'd0);

        // Full 32-nibble burst from slot 0
        Start = 1; Start_sel = 0; Len = 32;
        cycle();
        quiet(); In_valid = 1;
        for (int k = 0; k < 32; k++) begin
            In = 4'(k % 16);
            cycle();
        end
        quiet();
        for (int k = 0; k < 32; k++) expv[k*4 +: 4] = 4'(k % 16);
        chk("fill32_bank", Bank_flat, expv);
        chk("fill32_done", {127'd0, Done}, 128'd1);
        chk("fill32_ptr",  {123'd0, Ptr}, 128'd0);
        cycle();

        // Wrapping burst with gaps
        vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
        Start = 1; Start_sel = 30; Len = 4;
        cycle();
        quiet();
        for (int i = 0; i < 7; i++) begin
            In_valid = (i % 2 == 0);
            In       = vals[i/2];
            cycle();
            if (i == 1) chk("gap_in_ready", {127'd0, In_ready}, 128'd1);
        end
        quiet();
        chk("wrap_done", {127'd0, Done}, 128'd1);
        chk("wrap_ptr",  {123'd0, Ptr}, 128'd2);
        Rd_sel = 31; #1;
        chk("wrap_slot31", {124'd0, Rd_out}, 128'hB);
        Rd_sel = 1; #1;
        chk("wrap_slot1", {124'd0, Rd_out}, 128'hD);
        cycle();

        // Len=0, then Start held through the DONE cycle (ignored)
        Start = 1; Start_sel = 9; Len = 0;
        cycle();
        chk("len0_done", {127'd0, Done}, 128'd1);
        chk("len0_ptr",  {123'd0, Ptr}, 128'd9);
        Start_sel = 12; Len = 5;
        cycle();
        quiet();
        chk("start_in_done_busy", {127'd0, Busy}, 128'd0);
        cycle();

        // Len=40 clamps to 32 accepts
        Start = 1; Start_sel = 5; Len = 40;
        cycle();
        quiet(); In_valid = 1;
        acc = 0; budget = 100;
        while (!Done && budget > 0) begin
            if (In_ready) acc++;
            In = 4'($urandom_range(0, 15));
            cycle();
            budget--;
        end
        quiet();
        chk("len40_accepts", 128'(acc), 128'd32);
        chk("len40_done", {127'd0, Done}, 128'd1);
        cycle();

        // Addressed write and readback
        Wr_en = 1; Wr_sel = 17; Wr_data = 9;
        cycle();
        quiet(); Rd_sel = 17; #1;
        chk("wr_readback", {124'd0, Rd_out}, 128'd9);
        cycle();

        // Wr_en and Start ignored during FILL
        Start = 1; Start_sel = 0; Len = 2;
        cycle();
        quiet(); Wr_en = 1; Wr_sel = 17; Wr_data = 3; Start = 1; Start_sel = 20;
        cycle();
        quiet(); In_valid = 1; In = 4'h6;
        cycle(); cycle();
        quiet(); Rd_sel = 17; #1;
        chk("wr_in_fill_ignored", {124'd0, Rd_out}, 128'd9);
        cycle();

        // Start and Wr_en together: write dropped
        Start = 1; Start_sel = 3; Len = 1; Wr_en = 1; Wr_sel = 17; Wr_data = 2;
        cycle();
        quiet(); In_valid = 1; In = 4'h1;
        cycle();
        quiet(); Rd_sel = 17;
        cycle();

        // Clear with In_valid mid-burst
        Start = 1; Start_sel = 10; Len = 8;
        cycle();
        quiet(); In_valid = 1; In = 4'hF;
        cycle(); cycle();
        Clear = 1;
        cycle();
        quiet();
        chk("clear_bank", Bank_flat, 128'd0);
        chk("clear_busy", {127'd0, Busy}, 128'd0);
        chk("clear_done", {127'd0, Done}, 128'd0);
        cycle();

        // Asynchronous reset after 3 of 8 accepts
        Start = 1; Start_sel = 4; Len = 8;
        cycle();
        quiet(); In_valid = 1; In = 4'h7;
        cycle(); cycle(); cycle();
        reset = 1; #1;
        chk("areset_bank", Bank_flat, 128'd0);
        chk("areset_ptr",  {123'd0, Ptr}, 128'd0);
        chk("areset_busy", {127'd0, Busy}, 128'd0);
        chk("areset_done", {127'd0, Done}, 128'd0);
        cycle();
        reset = 0; quiet();
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            Start     = ($urandom_range(0, 7) == 0);
            Start_sel = 5'($urandom);
            Len       = 6'($urandom_range(0, 63));
            In        = 4'($urandom);
            In_valid  = $urandom_range(0, 1) == 1;
            Wr_en     = ($urandom_range(0, 3) == 0);
            Wr_sel    = 5'($urandom);
            Wr_data   = 4'($urandom);
            Clear     = ($urandom_range(0, 59) == 0);
            Rd_sel    = 5'($urandom);
            reset     = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 0; quiet();
        cycle(); cycle();

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
